// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with stall, flush and optional skid entry
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter bit SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  input  logic [CTRL_WIDTH-1:0] up_ctrl_i,
  input  logic [DATA_WIDTH-1:0] up_data_i,
  output logic                  dn_valid_o,
  input  logic                  dn_ready_i,
  output logic [CTRL_WIDTH-1:0] dn_ctrl_o,
  output logic [DATA_WIDTH-1:0] dn_data_o,
  output logic [1:0]            occ_o
);
  logic                  head_valid;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  push;
  logic                  pop;

  assign push       = up_valid_i & up_ready_o;
  assign pop        = head_valid & dn_ready_i;
  assign dn_valid_o = head_valid;
  assign dn_ctrl_o  = head_ctrl;
  assign dn_data_o  = head_data;

  if (SKID) begin : g_skid
    logic                  skid_valid;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    // Ready comes straight from the skid flop, so it never depends on dn_ready_i.
    assign up_ready_o = !skid_valid;
    assign occ_o      = {skid_valid, head_valid & !skid_valid};

    // Head/skid pair behaves as a 2-deep FIFO; control is zeroed whenever a slot empties.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        head_valid <= 1'b0;
        head_ctrl  <= '0;
        head_data  <= '0;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
        skid_data  <= '0;
      end else if (flush_i) begin
        head_valid <= 1'b0;
        head_ctrl  <= '0;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else if (pop) begin
        if (skid_valid) begin
          head_ctrl  <= skid_ctrl;
          head_data  <= skid_data;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end else if (push) begin
          head_ctrl <= up_ctrl_i;
          head_data <= up_data_i;
        end else begin
          head_valid <= 1'b0;
          head_ctrl  <= '0;
        end
      end else if (push) begin
        if (head_valid) begin
          skid_valid <= 1'b1;
          skid_ctrl  <= up_ctrl_i;
          skid_data  <= up_data_i;
        end else begin
          head_valid <= 1'b1;
          head_ctrl  <= up_ctrl_i;
          head_data  <= up_data_i;
        end
      end
    end
  end else begin : g_single
    assign up_ready_o = !head_valid | dn_ready_i;
    assign occ_o      = {1'b0, head_valid};

    // Single entry: load on push (replacing a popped head), drop to a bubble on pop or flush.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        head_valid <= 1'b0;
        head_ctrl  <= '0;
        head_data  <= '0;
      end else if (flush_i) begin
        head_valid <= 1'b0;
        head_ctrl  <= '0;
      end else if (push) begin
        head_valid <= 1'b1;
        head_ctrl  <= up_ctrl_i;
        head_data  <= up_data_i;
      end else if (pop) begin
        head_valid <= 1'b0;
        head_ctrl  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and scoreboard checks of pipe_stage_reg with and without skid entry
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          up_valid = 1'b0;
  logic          dn_ready = 1'b0;
  logic [CW-1:0] up_ctrl = '0;
  logic [DW-1:0] up_data = '0;

  logic          rdy1, v1, rdy0, v0;
  logic [CW-1:0] c1, c0;
  logic [DW-1:0] d1, d0;
  logic [1:0]    o1, o0;

  int errors = 0;
  int checks = 0;

  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];
  logic [CW+DW-1:0] h;
  logic [DW-1:0]    n;
  logic             push1, pop1, push0, pop0;

  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .up_valid_i(up_valid), .up_ready_o(rdy1), .up_ctrl_i(up_ctrl), .up_data_i(up_data),
    .dn_valid_o(v1), .dn_ready_i(dn_ready), .dn_ctrl_o(c1), .dn_data_o(d1), .occ_o(o1)
  );

  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(0)) u_flat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .up_valid_i(up_valid), .up_ready_o(rdy0), .up_ctrl_i(up_ctrl), .up_data_i(up_data),
    .dn_valid_o(v0), .dn_ready_i(dn_ready), .dn_ctrl_o(c0), .dn_data_o(d0), .occ_o(o0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    up_valid = v;
    up_ctrl  = c;
    up_data  = d;
  endtask

  task automatic head1(input string tag, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [1:0] o);
    chk({tag, "_v1"}, v1, 1'b1);
    chk({tag, "_c1"}, c1, c);
    chk({tag, "_d1"}, d1, d);
    chk({tag, "_o1"}, o1, o);
  endtask

  task automatic head0(input string tag, input logic [CW-1:0] c, input logic [DW-1:0] d);
    chk({tag, "_v0"}, v0, 1'b1);
    chk({tag, "_c0"}, c0, c);
    chk({tag, "_d0"}, d0, d);
    chk({tag, "_o0"}, o0, 2'd1);
  endtask

  initial begin
    // reset with garbage pushed upstream
    rst_n = 1'b0;
    dn_ready = 1'b1;
    drive(1'b1, 8'hFF, 16'hFFFF);
    cyc();
    cyc();
    rst_n = 1'b1;
    drive(1'b0, '0, '0);
    #1;
    chk("rst_v1", v1, 1'b0);
    chk("rst_c1", c1, 8'h00);
    chk("rst_d1", d1, 16'h0000);
    chk("rst_o1", o1, 2'd0);
    chk("rst_rdy1", rdy1, 1'b1);
    chk("rst_v0", v0, 1'b0);
    chk("rst_c0", c0, 8'h00);
    chk("rst_d0", d0, 16'h0000);
    chk("rst_o0", o0, 2'd0);
    chk("rst_rdy0", rdy0, 1'b1);

    // streaming with downstream always ready
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i * 16'h1111));
      cyc();
      head1("stream", CW'(i), DW'(i * 16'h1111), 2'd1);
      head0("stream", CW'(i), DW'(i * 16'h1111));
      chk("stream_rdy1", rdy1, 1'b1);
    end
    drive(1'b0, '0, '0);
    cyc();
    chk("stream_end_v1", v1, 1'b0);
    chk("stream_end_c1", c1, 8'h00);
    chk("stream_end_o1", o1, 2'd0);
    chk("stream_end_v0", v0, 1'b0);

    // backpressure through the skid entry
    dn_ready = 1'b0;
    drive(1'b1, 8'hA1, 16'hAAAA);
    cyc();
    head1("bp1_a", 8'hA1, 16'hAAAA, 2'd1);
    chk("bp1_a_rdy", rdy1, 1'b1);
    drive(1'b1, 8'hB2, 16'hBBBB);
    cyc();
    head1("bp1_b", 8'hA1, 16'hAAAA, 2'd2);
    chk("bp1_b_rdy", rdy1, 1'b0);
    drive(1'b1, 8'hC3, 16'hCCCC);
    cyc();
    head1("bp1_hold", 8'hA1, 16'hAAAA, 2'd2);
    chk("bp1_hold_rdy", rdy1, 1'b0);
    dn_ready = 1'b1;
    cyc();
    head1("bp1_gotb", 8'hB2, 16'hBBBB, 2'd1);
    chk("bp1_gotb_rdy", rdy1, 1'b1);
    cyc();
    head1("bp1_gotc", 8'hC3, 16'hCCCC, 2'd1);
    drive(1'b0, '0, '0);
    cyc();
    chk("bp1_end_v1", v1, 1'b0);
    chk("bp1_end_o1", o1, 2'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // backpressure on the single-entry stage
    dn_ready = 1'b0;
    drive(1'b1, 8'hA1, 16'hAAAA);
    cyc();
    head0("bp0_a", 8'hA1, 16'hAAAA);
    chk("bp0_a_rdy", rdy0, 1'b0);
    drive(1'b1, 8'hB2, 16'hBBBB);
    cyc();
    head0("bp0_hold", 8'hA1, 16'hAAAA);
    chk("bp0_hold_rdy", rdy0, 1'b0);
    dn_ready = 1'b1;
    #1;
    chk("bp0_comb_rdy", rdy0, 1'b1);
    cyc();
    head0("bp0_gotb", 8'hB2, 16'hBBBB);
    drive(1'b1, 8'hC3, 16'hCCCC);
    cyc();
    head0("bp0_gotc", 8'hC3, 16'hCCCC);
    drive(1'b0, '0, '0);
    dn_ready = 1'b0;
    #1;
    chk("bp0_drop_rdy", rdy0, 1'b0);
    cyc();
    head0("bp0_stable", 8'hC3, 16'hCCCC);
    dn_ready = 1'b1;
    cyc();
    chk("bp0_end_v0", v0, 1'b0);
    chk("bp0_end_c0", c0, 8'h00);
    chk("bp0_end_o0", o0, 2'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // flush a full skid stage while D is offered
    dn_ready = 1'b0;
    drive(1'b1, 8'h11, 16'h1111);
    cyc();
    drive(1'b1, 8'h22, 16'h2222);
    cyc();
    chk("fl_pre_o1", o1, 2'd2);
    drive(1'b1, 8'hDD, 16'hDDDD);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_v1", v1, 1'b0);
    chk("fl_c1", c1, 8'h00);
    chk("fl_o1", o1, 2'd0);
    chk("fl_rdy1", rdy1, 1'b1);
    chk("fl_v0", v0, 1'b0);
    chk("fl_c0", c0, 8'h00);
    chk("fl_o0", o0, 2'd0);
    cyc();
    chk("fl_stall_v1", v1, 1'b0);
    chk("fl_stall_c1", c1, 8'h00);
    dn_ready = 1'b1;
    cyc();
    chk("fl_no_d_v1", v1, 1'b0);
    chk("fl_no_d_v0", v0, 1'b0);

    // simultaneous push and pop with one entry held
    dn_ready = 1'b0;
    drive(1'b1, 8'hE5, 16'hEEEE);
    cyc();
    head1("pp_e", 8'hE5, 16'hEEEE, 2'd1);
    drive(1'b1, 8'hF6, 16'hFFFF);
    dn_ready = 1'b1;
    cyc();
    head1("pp_f", 8'hF6, 16'hFFFF, 2'd1);
    head0("pp_f", 8'hF6, 16'hFFFF);
    drive(1'b0, '0, '0);
    cyc();
    chk("pp_end_v1", v1, 1'b0);
    chk("pp_end_v0", v0, 1'b0);

    // random valid/ready/flush against FIFO scoreboards
    q1.delete();
    q0.delete();
    n = '0;
    for (int k = 0; k < 3000; k++) begin
      up_valid = ($urandom_range(0, 3) != 0);
      dn_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      up_ctrl  = CW'($urandom);
      up_data  = n;
      n++;
      #1;
      chk("rnd_v1", v1, q1.size() != 0);
      chk("rnd_o1", o1, q1.size());
      chk("rnd_rdy1", rdy1, q1.size() < 2);
      if (q1.size() != 0) begin
        h = q1[0];
        chk("rnd_c1", c1, h[CW+DW-1:DW]);
        chk("rnd_d1", d1, h[DW-1:0]);
      end else chk("rnd_bubble_c1", c1, 8'h00);
      chk("rnd_v0", v0, q0.size() != 0);
      chk("rnd_o0", o0, q0.size());
      chk("rnd_rdy0", rdy0, (q0.size() == 0) || dn_ready);
      if (q0.size() != 0) begin
        h = q0[0];
        chk("rnd_c0", c0, h[CW+DW-1:DW]);
        chk("rnd_d0", d0, h[DW-1:0]);
      end else chk("rnd_bubble_c0", c0, 8'h00);
      push1 = up_valid && (q1.size() < 2);
      pop1  = dn_ready && (q1.size() != 0);
      push0 = up_valid && ((q0.size() == 0) || dn_ready);
      pop0  = dn_ready && (q0.size() != 0);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (pop1) void'(q1.pop_front());
        if (push1) q1.push_back({up_ctrl, up_data});
        if (pop0) void'(q0.pop_front());
        if (push0) q0.push_back({up_ctrl, up_data});
      end
      cyc();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
